// File: rtl/cap_sense_pkg.sv
// Shared types and constants for the capacitive sensor scanner.
//   state_e  : scan FSM states (idle, electrodes charging, electrodes draining)
//   DebW     : width of each channel's debounce counter
//   timer_w(): phase timer width for a given half period
package cap_sense_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCharge,
        StDischarge
    } state_e;

    localparam int unsigned DebW = 4;

    localparam int unsigned HalfPeriodDefault = 50000;
    localparam int unsigned TimerWDefault     = $clog2(HalfPeriodDefault);

    // Timer counts 0 .. half_period-1, so $clog2 bits suffice.
    function automatic int unsigned timer_w(input int unsigned half_period);
        return (half_period > 1) ? $clog2(half_period) : 1;
    endfunction

endpackage

// File: rtl/cap_sense_scanner_if.sv
// Pad/game-logic side bundle of the capacitive sensor scanner.
//   enable, recal, sensor_in                        : toward the scanner
//   sensor_out, count, sample_valid, cal_done, touched : from the scanner
// master = environment / game logic, slave = scanner.
interface cap_sense_scanner_if #(
    parameter int unsigned NUM_CH = 9,
    parameter int unsigned CNT_W  = 17
);
    logic                    enable;
    logic                    recal;
    logic [NUM_CH-1:0]       sensor_in;
    logic                    sensor_out;
    logic [NUM_CH*CNT_W-1:0] count;
    logic                    sample_valid;
    logic                    cal_done;
    logic [NUM_CH-1:0]       touched;

    modport master (
        output enable, recal, sensor_in,
        input  sensor_out, count, sample_valid, cal_done, touched
    );

    modport slave (
        input  enable, recal, sensor_in,
        output sensor_out, count, sample_valid, cal_done, touched
    );
endinterface

// File: rtl/cap_sense_channel.sv
// One electrode: 2-flop synchroniser, first-high timer capture during CHARGE, baseline
// accumulation while calibrating, threshold compare and debounced touch flag.
//   clock, reset : system clock, async active-high reset
//   sensor_in    : raw electrode input (asynchronous)
//   charging     : FSM is in CHARGE this cycle
//   timer        : phase timer (cycle index inside CHARGE)
//   commit       : last CHARGE cycle of a completed scan
//   calib        : calibration in progress (baseline not yet valid)
//   cal_last     : this commit completes calibration
//   clear        : recalibration request, drop accumulated state
//   count        : latest charge time
//   touched      : debounced touch flag
module cap_sense_channel
    import cap_sense_pkg::*;
#(
    parameter int unsigned CNT_W       = 17,
    parameter int unsigned HALF_PERIOD = 50000,
    parameter int unsigned CAL_LOG2    = 3,
    parameter int unsigned THRESH      = 200,
    parameter int unsigned DEB         = 3,
    parameter int unsigned TMR_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sensor_in,
    input  logic             charging,
    input  logic [TMR_W-1:0] timer,
    input  logic             commit,
    input  logic             calib,
    input  logic             cal_last,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             touched
);
    localparam int unsigned AccW = CNT_W + CAL_LOG2;

    logic [1:0]       sync_q;
    logic             found_q, found_d, found_eff;
    logic [CNT_W-1:0] raw_q, raw_d, raw_base, raw_now;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] base_q, base_d;
    logic [AccW-1:0]  acc_q, acc_d, acc_sum;
    logic [DebW-1:0]  deb_q, deb_d;
    logic             touched_q, touched_d;
    logic             above;

    always_comb begin
        // Timer value 0 marks the first CHARGE cycle: start a fresh capture that
        // saturates at HALF_PERIOD if the input never goes high.
        found_eff = (timer == '0) ? 1'b0 : found_q;
        raw_base  = (timer == '0) ? CNT_W'(HALF_PERIOD) : raw_q;
        raw_now   = (sync_q[1] && !found_eff) ? CNT_W'(timer) : raw_base;
        acc_sum   = acc_q + AccW'(raw_now);
        above     = ({1'b0, raw_now} >= ({1'b0, base_q} + (CNT_W + 1)'(THRESH)));

        found_d   = found_q;
        raw_d     = raw_q;
        count_d   = count_q;
        base_d    = base_q;
        acc_d     = acc_q;
        deb_d     = deb_q;
        touched_d = touched_q;

        if (charging) begin
            raw_d   = raw_now;
            found_d = found_eff | sync_q[1];
        end

        if (clear) begin
            acc_d     = '0;
            deb_d     = '0;
            touched_d = 1'b0;
        end else if (commit) begin
            count_d = raw_now;
            if (calib) begin
                if (cal_last) begin
                    base_d = CNT_W'(acc_sum >> CAL_LOG2);
                    acc_d  = '0;
                end else begin
                    acc_d = acc_sum;
                end
            end else if (above != touched_q) begin
                if (deb_q == DebW'(DEB - 1)) begin
                    touched_d = !touched_q;
                    deb_d     = '0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end else begin
                deb_d = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q    <= '0;
            found_q   <= 1'b0;
            raw_q     <= '0;
            count_q   <= '0;
            base_q    <= '0;
            acc_q     <= '0;
            deb_q     <= '0;
            touched_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], sensor_in};
            found_q   <= found_d;
            raw_q     <= raw_d;
            count_q   <= count_d;
            base_q    <= base_d;
            acc_q     <= acc_d;
            deb_q     <= deb_d;
            touched_q <= touched_d;
        end
    end

    assign count   = count_q;
    assign touched = touched_q;

endmodule

// File: rtl/cap_sense_scanner.sv
// Capacitive sensor scanner: shared RC drive, per-electrode charge timing, self-calibrated
// baselines and debounced touch flags.
//   clock, reset : system clock, async active-high reset
//   bus (slave)  : enable, recal, sensor_in in; sensor_out, count, sample_valid, cal_done,
//                  touched out
module cap_sense_scanner
    import cap_sense_pkg::*;
#(
    parameter int unsigned NUM_CH      = 9,
    parameter int unsigned CNT_W       = 17,
    parameter int unsigned HALF_PERIOD = 50000,
    parameter int unsigned CAL_LOG2    = 3,
    parameter int unsigned THRESH      = 200,
    parameter int unsigned DEB         = 3
) (
    input logic                clock,
    input logic                reset,
    cap_sense_scanner_if.slave bus
);
    localparam int unsigned TmrW  = timer_w(HALF_PERIOD);
    localparam int unsigned ScanW = CAL_LOG2 + 1;

    state_e            state_q, state_d;
    logic [TmrW-1:0]   timer_q, timer_d;
    logic [ScanW-1:0]  scan_cnt_q, scan_cnt_d;
    logic              cal_done_q, cal_done_d;
    logic              sample_valid_q, sample_valid_d;
    logic              last_cycle, commit, clear, cal_last, calib, charging;

    logic [NUM_CH*CNT_W-1:0] count_w;
    logic [NUM_CH-1:0]       touched_w;

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        scan_cnt_d     = scan_cnt_q;
        cal_done_d     = cal_done_q;
        sample_valid_d = 1'b0;
        commit         = 1'b0;
        clear          = 1'b0;
        cal_last       = 1'b0;
        last_cycle     = (timer_q == TmrW'(HALF_PERIOD - 1));

        if (!bus.enable) begin
            state_d = StIdle;
            timer_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StCharge;
                    timer_d = '0;
                end
                StCharge: begin
                    // recal aborts the scan and drains the electrodes before recalibrating.
                    if (bus.recal || last_cycle) begin
                        state_d = StDischarge;
                        timer_d = '0;
                        commit  = !bus.recal;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                StDischarge: begin
                    if (last_cycle) begin
                        state_d = StCharge;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    timer_d = '0;
                end
            endcase
        end

        if (commit) begin
            sample_valid_d = 1'b1;
            if (!cal_done_q) begin
                if (scan_cnt_q == ScanW'((2 ** CAL_LOG2) - 1)) begin
                    cal_last   = 1'b1;
                    cal_done_d = 1'b1;
                    scan_cnt_d = '0;
                end else begin
                    scan_cnt_d = scan_cnt_q + 1'b1;
                end
            end
        end

        if (bus.recal) begin
            clear      = 1'b1;
            cal_done_d = 1'b0;
            scan_cnt_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            timer_q        <= '0;
            scan_cnt_q     <= '0;
            cal_done_q     <= 1'b0;
            sample_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            scan_cnt_q     <= scan_cnt_d;
            cal_done_q     <= cal_done_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    assign charging = (state_q == StCharge);
    assign calib    = !cal_done_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        cap_sense_channel #(
            .CNT_W       (CNT_W),
            .HALF_PERIOD (HALF_PERIOD),
            .CAL_LOG2    (CAL_LOG2),
            .THRESH      (THRESH),
            .DEB         (DEB),
            .TMR_W       (TmrW)
        ) u_ch (
            .clock     (clock),
            .reset     (reset),
            .sensor_in (bus.sensor_in[i]),
            .charging  (charging),
            .timer     (timer_q),
            .commit    (commit),
            .calib     (calib),
            .cal_last  (cal_last),
            .clear     (clear),
            .count     (count_w[i*CNT_W +: CNT_W]),
            .touched   (touched_w[i])
        );
    end

    // Driven straight from the state register so an async reset drops the drive at once.
    assign bus.sensor_out   = charging;
    assign bus.sample_valid = sample_valid_q;
    assign bus.cal_done     = cal_done_q;
    assign bus.count        = count_w;
    assign bus.touched      = touched_w;

endmodule

// File: tb/tb_cap_sense_scanner.sv
module tb_cap_sense_scanner;
    localparam int NCH   = 3;
    localparam int CW    = 17;
    localparam int HP    = 100;
    localparam int CALL  = 2;
    localparam int TH    = 10;
    localparam int DB    = 2;
    localparam int NEVER = 1000;

    logic clock = 1'b0;
    logic reset = 1'b1;

    cap_sense_scanner_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    cap_sense_scanner #(
        .NUM_CH      (NCH),
        .CNT_W       (CW),
        .HALF_PERIOD (HP),
        .CAL_LOG2    (CALL),
        .THRESH      (TH),
        .DEB         (DB)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    // Electrode response: input goes high dly[i] cycles after the drive rises (NEVER = stays low).
    int dly [NCH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- electrode environment ----------------
    initial begin
        int  k;
        logic p;
        k = 0;
        p = 1'b0;
        bus.sensor_in = '0;
        forever begin
            @(posedge clock);
            #1;
            if (bus.sensor_out) k = p ? k + 1 : 0;
            p = bus.sensor_out;
            for (int i = 0; i < NCH; i++) bus.sensor_in[i] = bus.sensor_out && (k >= dly[i]);
        end
    end

    // ---------------- behavioural model ----------------
    // Scanning position within the 2*HP drive period; charge time derived from the delay
    // plus the two synchroniser cycles, clipped at HP.
    bit       m_run = 1'b0;
    int       m_pos = 0;
    bit       m_sv  = 1'b0;
    bit       m_cal = 1'b0;
    int       m_ncal = 0;
    int       m_acc   [NCH];
    int       m_base  [NCH];
    int       m_deb   [NCH];
    int       m_count [NCH];
    bit [NCH-1:0] m_touch = '0;

    task automatic model_clear_cal();
        m_cal   = 1'b0;
        m_ncal  = 0;
        m_touch = '0;
        for (int i = 0; i < NCH; i++) begin
            m_acc[i] = 0;
            m_deb[i] = 0;
        end
    endtask

    task automatic model_scan_done();
        int raw;
        bit above;
        m_sv = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            raw = (dly[i] + 2 > HP) ? HP : dly[i] + 2;
            m_count[i] = raw;
            if (!m_cal) begin
                m_acc[i] += raw;
            end else begin
                above = (raw >= m_base[i] + TH);
                if (above != m_touch[i]) begin
                    m_deb[i]++;
                    if (m_deb[i] == DB) begin
                        m_touch[i] = ~m_touch[i];
                        m_deb[i] = 0;
                    end
                end else begin
                    m_deb[i] = 0;
                end
            end
        end
        if (!m_cal) begin
            m_ncal++;
            if (m_ncal == (1 << CALL)) begin
                for (int i = 0; i < NCH; i++) m_base[i] = m_acc[i] >> CALL;
                m_cal = 1'b1;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < NCH; i++) begin
            m_acc[i] = 0; m_base[i] = 0; m_deb[i] = 0; m_count[i] = 0;
        end
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                m_run = 1'b0;
                m_pos = 0;
                m_sv  = 1'b0;
                model_clear_cal();
                for (int i = 0; i < NCH; i++) begin
                    m_base[i] = 0; m_count[i] = 0;
                end
            end else begin
                m_sv = 1'b0;
                if (bus.recal) model_clear_cal();
                if (!bus.enable) begin
                    m_run = 1'b0;
                end else if (!m_run) begin
                    m_run = 1'b1;
                    m_pos = 0;
                end else if (bus.recal && m_pos < HP) begin
                    m_pos = HP;
                end else begin
                    if (m_pos == HP - 1) model_scan_done();
                    m_pos = (m_pos + 1) % (2 * HP);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clock);
            check("sensor_out", bus.sensor_out, (m_run && m_pos < HP));
            check("sample_valid", bus.sample_valid, m_sv);
            check("cal_done", bus.cal_done, m_cal);
            check("touched", bus.touched, m_touch);
            for (int i = 0; i < NCH; i++) check("count", bus.count[i*CW +: CW], m_count[i]);
        end
    end

    // ---------------- directed sequence ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_sv();
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (bus.sample_valid) break;
        end
        check("sample_valid wait", bus.sample_valid, 1);
    endtask

    task automatic wait_rise();
        logic p;
        p = bus.sensor_out;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (bus.sensor_out && !p) break;
            p = bus.sensor_out;
        end
        check("charge start", bus.sensor_out, 1);
    endtask

    task automatic check_counts(input string name, input int c0, input int c1, input int c2);
        check({name, " ch0"}, bus.count[0*CW +: CW], c0);
        check({name, " ch1"}, bus.count[1*CW +: CW], c1);
        check({name, " ch2"}, bus.count[2*CW +: CW], c2);
    endtask

    initial begin
        int n;
        bus.enable = 1'b0;
        bus.recal  = 1'b0;
        for (int i = 0; i < NCH; i++) dly[i] = 20;

        repeat (3) @(negedge clock);
        check("reset sensor_out", bus.sensor_out, 0);
        check("reset sample_valid", bus.sample_valid, 0);
        check("reset cal_done", bus.cal_done, 0);
        check("reset touched", bus.touched, 0);
        check_counts("reset count", 0, 0, 0);
        reset = 1'b0;
        tick();
        bus.enable = 1'b1;

        // Calibration: four scans at 22 cycles.
        for (int s = 1; s <= 4; s++) begin
            wait_sv();
            check_counts("cal count", 22, 22, 22);
            check("cal_done after scan", bus.cal_done, (s == 4));
        end

        // ch1 slowed to 40 -> count 42, above 22+10; touched after two scans.
        dly[1] = 40;
        wait_sv();
        check("touch deb1", bus.touched, 3'b000);
        wait_sv();
        check_counts("slow count", 22, 42, 22);
        check("touch set", bus.touched, 3'b010);
        dly[1] = 20;
        wait_sv();
        check("touch hold", bus.touched, 3'b010);
        wait_sv();
        check("touch clear", bus.touched, 3'b000);

        // ch0 follows the drive immediately, ch2 never rises.
        dly[0] = 0;
        dly[2] = NEVER;
        wait_sv();
        check_counts("extreme count", 2, 22, 100);
        wait_sv();
        check("touch ch2", bus.touched, 3'b100);
        for (int i = 0; i < NCH; i++) dly[i] = 20;
        wait_sv();
        check("touch ch2 hold", bus.touched, 3'b100);

        // Drop enable at cycle 50 of CHARGE.
        wait_rise();
        repeat (50) tick();
        bus.enable = 1'b0;
        tick();
        check("drop sensor_out", bus.sensor_out, 0);
        repeat (30) @(negedge clock);
        check("drop sample_valid", bus.sample_valid, 0);
        check_counts("drop count", 22, 22, 22);
        check("drop touched", bus.touched, 3'b100);
        check("drop cal_done", bus.cal_done, 1);

        // Re-enable, then recal on the last CHARGE cycle.
        bus.enable = 1'b1;
        wait_rise();
        repeat (HP - 1) tick();
        bus.recal = 1'b1;
        tick();
        bus.recal = 1'b0;
        @(negedge clock);
        check("recal sample_valid", bus.sample_valid, 0);
        check("recal cal_done", bus.cal_done, 0);
        check("recal touched", bus.touched, 0);
        check("recal sensor_out", bus.sensor_out, 0);
        n = 1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (bus.sensor_out) break;
            n++;
        end
        check("recal discharge len", n, HP);

        for (int s = 1; s <= 4; s++) begin
            wait_sv();
            check("recal cal_done", bus.cal_done, (s == 4));
        end

        dly[1] = 40;
        wait_sv();
        wait_sv();
        check("pre-reset touched", bus.touched, 3'b010);

        // Async reset in the middle of DISCHARGE.
        repeat (30) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("async sensor_out", bus.sensor_out, 0);
        check("async sample_valid", bus.sample_valid, 0);
        check("async cal_done", bus.cal_done, 0);
        check("async touched", bus.touched, 0);
        check_counts("async count", 0, 0, 0);
        bus.enable = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks so far", n_chk);
        $fatal(1, "watchdog");
    end

endmodule
